// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: circular trace capture of retiring pc, decode ir and data-memory writes
// with free-run, store-only and pc-triggered modes plus one-cycle indexed readback.
module cpu_trace_buffer #(
  parameter int PC_W = 16,
  parameter int IR_W = 16,
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int REC_W = PC_W + IR_W + 1 + AW + DW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [PC_W-1:0]  trig_pc,
  input  logic [CW-1:0]    post_len,
  input  logic [PC_W-1:0]  pc,
  input  logic [IR_W-1:0]  ir,
  input  logic             d_we,
  input  logic [AW-1:0]    d_addr,
  input  logic [DW-1:0]    d_data,
  input  logic             rd_req,
  input  logic [CW-1:0]    rd_idx,
  output logic             rd_valid,
  output logic [REC_W-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             wrapped,
  output logic             busy,
  output logic             done
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_CAP = 2'd2, S_DONE = 2'd3;
  logic [1:0] r_state, r_mode;
  logic [PC_W-1:0] r_trig;
  logic [CW-1:0] r_len, r_count;
  logic [PW-1:0] r_ptr;
  logic r_wrapped;
  logic [REC_W-1:0] r_mem [DEPTH];
  logic w_idle, w_we, w_last;
  logic [PW-1:0] w_slot;
  logic [CW-1:0] w_cnt_inc;
  assign w_idle = r_state == S_IDLE || r_state == S_DONE;
  // a stop while armed must not let a coincident trigger record slip in
  assign w_we = r_state == S_CAP ? enable & (r_mode != 2'd1 | d_we)
              : r_state == S_ARMED & enable & ~stop & (pc == r_trig);
  assign w_cnt_inc = r_count + CW'(1);
  assign w_last = r_mode == 2'd2 && w_cnt_inc == r_len;
  assign w_slot = (r_wrapped ? r_ptr : '0) + rd_idx[PW-1:0];
  assign count = r_count;
  assign wrapped = r_wrapped;
  assign busy = r_state == S_ARMED || r_state == S_CAP;
  assign done = r_state == S_DONE;
  always_ff @(posedge clk)
    if (w_we) r_mem[r_ptr] <= {pc, ir, d_we, d_addr, d_data};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mode <= '0;
      r_trig <= '0;
      r_len <= '0;
      r_count <= '0;
      r_ptr <= '0;
      r_wrapped <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_valid <= w_idle & rd_req;
      if (w_idle & rd_req) rd_data <= rd_idx < r_count ? r_mem[w_slot] : '0;
      if (w_idle & start) begin
        r_state <= mode == 2'd2 ? S_ARMED : S_CAP;
        r_mode <= mode;
        r_trig <= trig_pc;
        r_len <= (post_len == '0 || post_len > FULL) ? FULL : post_len;
        r_count <= '0;
        r_ptr <= '0;
        r_wrapped <= 1'b0;
      end else begin
        if (w_we) begin
          r_ptr <= r_ptr + PW'(1);
          r_count <= r_count == FULL ? r_count : w_cnt_inc;
          if (r_count == FULL) r_wrapped <= 1'b1;
        end
        if (!w_idle & stop) r_state <= S_DONE;
        else if (w_we) r_state <= w_last ? S_DONE : S_CAP;
      end
    end
  end
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: directed stimulus with a readback scoreboard checked by a negedge monitor.
module tb_cpu_trace_buffer;
  localparam int CW = 5;
  localparam int REC_W = 57;
  logic clk = 0, reset = 1, enable = 0, start = 0, stop = 0;
  logic [1:0] mode = 0;
  logic [15:0] trig_pc = 0, pc = 0, ir = 0, d_data = 0;
  logic [CW-1:0] post_len = 0, rd_idx = 0;
  logic d_we = 0, rd_req = 0;
  logic [7:0] d_addr = 0;
  logic rd_valid, wrapped, busy, done;
  logic [REC_W-1:0] rd_data;
  logic [CW-1:0] count;
  int total = 0, bad = 0;
  logic [REC_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  cpu_trace_buffer dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .stop(stop), .mode(mode),
    .trig_pc(trig_pc), .post_len(post_len), .pc(pc), .ir(ir), .d_we(d_we), .d_addr(d_addr),
    .d_data(d_data), .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data),
    .count(count), .wrapped(wrapped), .busy(busy), .done(done)
  );

  function automatic logic [REC_W-1:0] rec(input logic [15:0] p, input logic w = 0,
                                           input logic [7:0] a = 0, input logic [15:0] d = 0);
    return {p, p + 16'h1000, w, a, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rd_valid: got rd_valid=1 data=%0h expected rd_valid=0", rd_data);
      end else chk("rd_data", rd_data, exp_q.pop_front());
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] p, input logic en, input logic w = 0,
                       input logic [7:0] a = 0, input logic [15:0] d = 0);
    pc = p; ir = p + 16'h1000; enable = en; d_we = w; d_addr = a; d_data = d;
    tick();
  endtask

  task automatic arm(input logic [1:0] m, input logic [15:0] t, input logic [CW-1:0] l);
    mode = m; trig_pc = t; post_len = l; start = 1; enable = 0;
    tick();
    start = 0;
  endtask

  task automatic halt;
    stop = 1; enable = 0;
    tick();
    stop = 0;
  endtask

  task automatic rd(input logic [CW-1:0] idx, input logic [REC_W-1:0] e);
    rd_req = 1; rd_idx = idx;
    exp_q.push_back(e);
    tick();
    rd_req = 0;
  endtask

  task automatic drain;
    int n = 0;
    while (exp_q.size() != 0 && n < 8) begin
      tick();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending reads expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    tick(); tick();
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_count", count, 0);
    chk("rst_wrapped", wrapped, 0); chk("rst_rd_valid", rd_valid, 0); chk("rst_rd_data", rd_data, 0);
    reset = 0;
    // mode 0 basic
    arm(0, 0, 0);
    chk("m0_busy", busy, 1);
    for (int i = 0; i < 5; i++) drive(16'(i), 1);
    halt();
    chk("m0_done", done, 1); chk("m0_count", count, 5); chk("m0_wrapped", wrapped, 0);
    for (int i = 0; i < 5; i++) rd(CW'(i), rec(16'(i)));
    rd(5, '0);
    drain();
    // mode 0 wrap
    arm(0, 0, 0);
    for (int i = 0; i < 20; i++) drive(16'(i), 1);
    halt();
    chk("wrap_count", count, 16); chk("wrap_wrapped", wrapped, 1);
    rd(0, rec(16'd4)); rd(15, rec(16'd19));
    drain();
    // mode 1 store-only
    arm(1, 0, 0);
    for (int i = 1; i <= 10; i++) drive(16'(i), 1, i == 2 || i == 5 || i == 9, 8'(i), 16'h00AA);
    halt();
    chk("m1_count", count, 3);
    rd(0, rec(16'd2, 1, 8'd2, 16'h00AA)); rd(1, rec(16'd5, 1, 8'd5, 16'h00AA));
    rd(2, rec(16'd9, 1, 8'd9, 16'h00AA));
    drain();
    // mode 2 triggered
    arm(2, 16'h0007, 4);
    for (int i = 0; i <= 20; i++) begin
      drive(16'(i), i != 9);
      if (i == 6) begin chk("m2_armed_count", count, 0); chk("m2_armed_busy", busy, 1); end
      chk("m2_done", done, i >= 11);
    end
    chk("m2_count", count, 4);
    rd(0, rec(16'd7)); rd(1, rec(16'd8)); rd(2, rec(16'd10)); rd(3, rec(16'd11));
    drain();
    // stop while armed, with readback attempted while busy
    arm(2, 16'hFFFF, 4);
    drive(1, 1);
    rd_req = 1; rd_idx = 0;
    tick();
    rd_req = 0;
    chk("busy_rd_valid", rd_valid, 0);
    halt();
    chk("armstop_done", done, 1); chk("armstop_count", count, 0); chk("armstop_busy", busy, 0);
    // start+stop together in capture: stop wins, sample still written
    arm(0, 0, 0);
    drive(16'h20, 1); drive(16'h21, 1);
    start = 1; stop = 1;
    drive(16'h22, 1);
    start = 0; stop = 0; enable = 0;
    chk("ss_done", done, 1); chk("ss_count", count, 3);
    rd(2, rec(16'h22));
    drain();
    // post_len=0 captures full depth
    arm(2, 0, 0);
    for (int i = 0; i < 20; i++) begin
      drive(16'(i), 1);
      if (i == 14) chk("pl0_notdone", done, 0);
    end
    chk("pl0_done", done, 1); chk("pl0_count", count, 16); chk("pl0_wrapped", wrapped, 0);
    rd(0, rec(16'd0)); rd(15, rec(16'd15)); rd(16, '0);
    drain();
    // reset drops an in-flight read
    rd_req = 1; reset = 1;
    tick();
    rd_req = 0; reset = 0;
    chk("rstrd_valid", rd_valid, 0); chk("rstrd_done", done, 0);
    // reset mid-capture
    arm(0, 0, 0);
    for (int i = 0; i < 3; i++) drive(16'(i), 1);
    chk("rc_count3", count, 3);
    reset = 1;
    drive(3, 1);
    reset = 0; enable = 0;
    chk("rc_busy", busy, 0); chk("rc_done", done, 0); chk("rc_count", count, 0);
    chk("rc_rd_valid", rd_valid, 0); chk("rc_wrapped", wrapped, 0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
Parametrised on-chip trace capture unit for the pipelined CPU: samples the retiring pc, decode-stage instruction and data-memory write bus into a circular record buffer. Three capture modes: free-run, store-only, pc-triggered. Readback after capture through a one-cycle request/valid port. Replaces simulation-only $monitor/$display observation of pc, ir and data-memory activity with synthesizable hardware usable on silicon and in regression.

Parameters:
PC_W, 16, pc width
IR_W, 16, instruction width
AW, 8, data-memory address width
DW, 16, data-memory data width
DEPTH, 16, record slots; power of 2, >=2
CW, $clog2(DEPTH)+1, count/index width (localparam, derived)
REC_W, PC_W+IR_W+1+AW+DW, record width (localparam: {pc, ir, d_we, d_addr, d_data})

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
enable  in  1  sample qualifier (CPU enable/not stalled)
start  in  1  one-cycle arm pulse
stop  in  1  one-cycle stop pulse
mode  in  2  capture mode, latched on accepted start
trig_pc  in  PC_W  trigger pc, latched on accepted start
post_len  in  CW  records after trigger (mode 2), latched on accepted start
pc  in  PC_W  CPU pc
ir  in  IR_W  decode-stage instruction
d_we  in  1  data-memory write enable
d_addr  in  AW  data-memory address
d_data  in  DW  data-memory write data
rd_req  in  1  readback request
rd_idx  in  CW  record index, 0 = oldest
rd_valid  out  1  readback data valid (1-cycle pulse)
rd_data  out  REC_W  readback record
count  out  CW  valid records, saturates at DEPTH
wrapped  out  1  oldest record overwritten at least once
busy  out  1  state ARMED or CAPTURE
done  out  1  state DONE

Behaviour:
- Reset state: IDLE. wr_ptr=0, count=0, wrapped=0, rd_valid=0, rd_data=0, busy=0, done=0. Buffer contents need not reset.
- States: IDLE, ARMED, CAPTURE, DONE.
- Accepted start: start=1 in IDLE or DONE.
  - Clears wr_ptr, count, wrapped; latches mode, trig_pc, post_len.
  - Next state ARMED for mode 2, else CAPTURE.
- start in ARMED or CAPTURE: ignored.
- Sample condition in CAPTURE:
  - mode 0 and 3: enable=1.
  - mode 1: enable & d_we.
  - mode 2: enable=1.
- ARMED (mode 2): enable & (pc==trig_pc) writes that cycle as record 0 and enters CAPTURE; the trigger record counts toward post_len.
- Write: record goes into slot wr_ptr at the sampling edge; wr_ptr increments mod DEPTH; count +1 saturating at DEPTH. Updated count is visible the cycle after the sample.
- Wrap: a write with count==DEPTH overwrites the oldest record and sets wrapped=1 (sticky until next accepted start).
- Mode 2 termination:
  - Effective length L = post_len; if post_len==0 or post_len>DEPTH, L = DEPTH.
  - Enter DONE on the edge that writes the L-th record. Mode 2 never wraps.
- stop=1 in CAPTURE: that cycle's sample, if any, is written; then DONE.
- stop=1 in ARMED: DONE with count=0.
- stop in IDLE or DONE: ignored.
- start and stop in the same cycle:
  - In IDLE or DONE, start wins.
  - In ARMED or CAPTURE, stop wins.
- Readback, accepted only in IDLE or DONE:
  - rd_req=1 gives rd_valid=1 on the next cycle for one cycle.
  - rd_idx<count: rd_data = slot (base+rd_idx) mod DEPTH, where base = wrapped ? wr_ptr : 0.
  - rd_idx>=count: rd_data=0.
  - Back-to-back requests give one result per cycle.
- rd_req in ARMED or CAPTURE: ignored; rd_valid stays 0.
- rd_data holds its last value when rd_valid=0.
- reset mid-capture: returns to IDLE with all outputs at reset values on the next edge; any in-flight rd_valid is dropped.

Test Plan:
- Mode 0, DEPTH=16: start, 5 enabled cycles with pc=0..4 then stop -> done=1, count=5, wrapped=0; rd_idx 0..4 return pc 0..4; rd_idx 5 returns 0 with rd_valid=1.
- Mode 0 wrap: 20 enabled samples with pc=0..19 then stop -> count=16, wrapped=1; rd_idx 0 returns pc=4, rd_idx 15 returns pc=19.
- Mode 1: 10 enabled cycles with d_we on cycles 2, 5, 9 (d_addr=2,5,9, d_data=0x00AA) -> count=3; records in order with d_we=1.
- Mode 2: trig_pc=0x0007, post_len=4, pc counting 0..20, enable low on one cycle after trigger -> ARMED until pc=7; records pc 7, 8, 10, 11 (stalled cycle skipped); done asserts on the edge writing pc 11.
- Corner: stop in ARMED -> count=0, done=1. start+stop together in CAPTURE -> DONE. rd_req while busy -> no rd_valid. post_len=0 -> 16 records captured.
- Reset asserted in CAPTURE after 3 samples -> next cycle IDLE, count=0, busy=0, done=0, rd_valid=0.
